// File: rtl/anatop_emu.sv
// Digital stand-in for the comparator/cap-bank analog macro: integrates level minus
// switched cap-bank charge and returns a delayed comparator decision after a settle phase.
module anatop_emu #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned DELAY  = 2,
  parameter int unsigned SETTLE = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] level,
  input  logic             enable,
  output logic             ctrl,
  output logic             ready,
  output logic             overflow
);

  localparam int unsigned AccW = WIDTH + 2;
  localparam int unsigned SumW = WIDTH + 3;
  localparam int unsigned CntW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  localparam logic [CntW-1:0] CntLast = CntW'(SETTLE - 1);

  localparam logic StSettle = 1'b0;
  localparam logic StRun    = 1'b1;

  localparam logic signed [SumW-1:0] AccMax    = SumW'((2 ** (WIDTH + 1)) - 1);
  localparam logic signed [SumW-1:0] AccMin    = SumW'(-(2 ** (WIDTH + 1)));
  localparam logic signed [SumW-1:0] FullScale = SumW'(2 ** WIDTH);

  logic                   state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic signed [AccW-1:0] acc_q, acc_d;
  logic [DELAY-1:0]       dly_q, dly_d;
  logic                   ovf_q, ovf_d;

  logic signed [SumW-1:0] acc_ext;
  logic signed [SumW-1:0] lvl_ext;
  logic signed [SumW-1:0] sub;
  logic signed [SumW-1:0] sum;
  logic                   decision;

  // One guard bit beyond the accumulator range keeps the sum exact before saturation.
  always_comb begin
    acc_ext  = {acc_q[AccW-1], acc_q};
    lvl_ext  = {3'b000, level};
    sub      = '0;
    if (enable) begin
      sub = FullScale;
    end
    sum      = acc_ext + lvl_ext - sub;
    decision = ~acc_q[AccW-1];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    dly_d   = dly_q;
    ovf_d   = ovf_q;
    case (state_q)
      StSettle: begin
        acc_d = '0;
        dly_d = '0;
        if (cnt_q == CntLast) begin
          state_d = StRun;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StRun: begin
        // Landing exactly on a rail is not an overflow; only exceeding it is.
        if (sum > AccMax) begin
          acc_d = AccMax[AccW-1:0];
          ovf_d = 1'b1;
        end else if (sum < AccMin) begin
          acc_d = AccMin[AccW-1:0];
          ovf_d = 1'b1;
        end else begin
          acc_d = sum[AccW-1:0];
        end
        dly_d[0] = decision;
        for (int i = 1; i < DELAY; i++) begin
          dly_d[i] = dly_q[i-1];
        end
      end
      default: state_d = StSettle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StSettle;
      cnt_q   <= '0;
      acc_q   <= '0;
      dly_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      dly_q   <= dly_d;
      ovf_q   <= ovf_d;
    end
  end

  // All outputs come straight from flops, so enable may be looped back from ctrl.
  assign ctrl     = dly_q[DELAY-1];
  assign ready    = (state_q == StRun);
  assign overflow = ovf_q;

endmodule

// File: tb/tb_anatop_emu.sv
// Scoreboard bench for anatop_emu: default build plus a DELAY=1/SETTLE=1 build.
module tb_anatop_emu;

  logic       clk;
  logic       rst_n;
  logic [3:0] level;
  logic       enable;
  logic       ctrl, ready, overflow;
  logic       ctrl1, ready1, overflow1;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    string tag;
    logic  c0, r0, o0;
    logic  chk1;
    logic  c1, r1, o1;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  anatop_emu #(.WIDTH(4), .DELAY(2), .SETTLE(8)) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .level    (level),
    .enable   (enable),
    .ctrl     (ctrl),
    .ready    (ready),
    .overflow (overflow)
  );

  anatop_emu #(.WIDTH(4), .DELAY(1), .SETTLE(1)) u_dut_fast (
    .clk      (clk),
    .rst_n    (rst_n),
    .level    (4'd8),
    .enable   (1'b0),
    .ctrl     (ctrl1),
    .ready    (ready1),
    .overflow (overflow1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_bit(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs at the falling edge and queue the outputs expected after
  // the following rising edge.
  task automatic step(input logic r, input logic [3:0] l, input logic e, input logic lp,
                      input logic ec, input logic er, input logic eo,
                      input logic c1, input logic ec1, input logic er1, input logic eo1,
                      input string tag);
    exp_t x;
    @(negedge clk);
    rst_n  = r;
    level  = l;
    enable = lp ? ctrl : e;
    x.tag  = tag;
    x.c0   = ec;
    x.r0   = er;
    x.o0   = eo;
    x.chk1 = c1;
    x.c1   = ec1;
    x.r1   = er1;
    x.o1   = eo1;
    sb.push_back(x);
  endtask

  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      chk_bit({mon_e.tag, " ctrl"}, ctrl, mon_e.c0);
      chk_bit({mon_e.tag, " ready"}, ready, mon_e.r0);
      chk_bit({mon_e.tag, " overflow"}, overflow, mon_e.o0);
      if (mon_e.chk1) begin
        chk_bit({mon_e.tag, " fast ctrl"}, ctrl1, mon_e.c1);
        chk_bit({mon_e.tag, " fast ready"}, ready1, mon_e.r1);
        chk_bit({mon_e.tag, " fast overflow"}, overflow1, mon_e.o1);
      end
    end
  end

  initial begin
    int m;
    int ones;
    rst_n  = 1'b0;
    level  = '0;
    enable = 1'b0;

    for (int i = 0; i < 2; i++) begin
      step(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "reset");
    end

    // Settle then positive saturation; m is the RUN cycle whose outputs are checked.
    // acc: 0, 8, 16, 24, 31(sat) -> overflow visible from RUN cycle 5.
    for (int s = 1; s <= 28; s++) begin
      m = s - 7;
      step(1'b1, 4'd8, 1'b0, 1'b0, m >= 3, s >= 8, m >= 5,
           1'b1, s >= 2, 1'b1, s >= 5, "pos_sat");
    end

    step(1'b0, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "mid_reset");

    // acc: 0, -16, -32 (exact rail, no overflow), -48 -> -32 with overflow.
    for (int s = 1; s <= 16; s++) begin
      m = s - 7;
      step(1'b1, 4'd0, 1'b1, 1'b0, m == 3, s >= 8, m >= 4,
           1'b0, 1'b0, 1'b0, 1'b0, "neg_sat");
    end

    step(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "reset2");

    // Closed loop: ctrl is 0 for RUN cycles 1-2, then five 1s / five 0s from cycle 3.
    ones = 0;
    for (int s = 1; s <= 110; s++) begin
      m = s - 7;
      step(1'b1, 4'd8, 1'b0, 1'b1, (m >= 3) && (((m - 3) % 10) < 5), s >= 8, 1'b0,
           1'b0, 1'b0, 1'b0, 1'b0, "loop");
      if ((s - 8 >= 3) && (s - 8 <= 102) && (ctrl === 1'b1)) begin
        ones++;
      end
    end
    chk_int("loop ctrl density", ones, 50);

    @(posedge clk);
    #2;
    chk_int("scoreboard drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/anatop_emu.md
# anatop_emu

Cycle-accurate digital responder for the analog front-end's comparator/capacitor-bank interface, used in place of the analog macro for FPGA prototyping and digital-only verification of the digital back end. It consumes the cap-bank `enable` request from the digital loop, integrates an emulated input level minus the switched cap-bank charge in a saturating accumulator, and returns a clocked comparator decision `ctrl` with configurable latency. A settle phase after reset models comparator/bias start-up before decisions become valid.

## Interface
- `WIDTH`, 4: bit width of `level`; cap-bank full-scale charge is 2**WIDTH.
- `DELAY`, 2: comparator latency in cycles, decision to `ctrl`; must be ≥1.
- `SETTLE`, 8: settle-phase length in cycles after reset release; must be ≥1.

- `clk`  in  1  comparator clock; all state on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `level`  in  WIDTH  emulated input amplitude, unsigned, sampled every cycle.
- `enable`  in  1  cap-bank enable from the digital loop; 1 subtracts 2**WIDTH this cycle.
- `ctrl`  out  1  registered comparator decision.
- `ready`  out  1  high in RUN; decisions on `ctrl` are valid.
- `overflow`  out  1  sticky; set when the accumulator saturates.

## Operation
- Accumulator `acc`: signed, WIDTH+2 bits, range [-2**(WIDTH+1), 2**(WIDTH+1)-1] (WIDTH=4: -32..31).
- FSM states: SETTLE, RUN. Reset → SETTLE.
  - SETTLE: settle counter increments from 0; `acc` held 0; delay line held 0; `level`/`enable` ignored. Counter at SETTLE-1 → RUN next edge.
  - RUN: stays until reset. No other exits.
- RUN per-cycle update, computed at full precision before saturation: sum = acc + level − (enable ? 2**WIDTH : 0).
  - sum > max → acc = max, overflow ← 1; sum < min → acc = min, overflow ← 1; else acc = sum.
  - Saturation at exactly min/max without exceeding it does not set overflow.
- Decision d = (acc ≥ 0), i.e. inverted sign bit of the current (pre-update) `acc`.
- d enters a DELAY-stage shift register; `ctrl` = last stage. In SETTLE the shift register is forced to 0.
- `overflow` clears only on reset.
- `enable` and `level` take effect in the same cycle they are presented; no latching, no handshake.

## Timing
- Reset values (edge with rst_n=0): state SETTLE, counter 0, acc 0, delay line 0, `ctrl`=0, `ready`=0, `overflow`=0.
- `ready` rises on the edge ending the SETTLE-th cycle after reset release; with SETTLE=8 it is first seen high in cycle 9.
- First RUN cycle: acc=0 → d=1; `ctrl` shows it DELAY cycles later. The preceding DELAY RUN cycles show `ctrl`=0 (flushed line).
- Latency `enable` → acc: 1 cycle. Latency acc → `ctrl`: DELAY cycles.
- Reset mid-RUN: next edge returns all state to reset values, and a full SETTLE phase repeats.
- `rst_n` low for one cycle is sufficient.
- `ctrl` and `ready` are registered outputs with no combinational path from inputs. `enable` may be tied combinationally to `ctrl` externally without creating a loop.

## Test plan
- Reset/settle: rst_n low 2 cycles, then high. `ctrl`=0, `ready`=0, `overflow`=0 for 8 cycles; `ready`=1 from cycle 9.
- Positive saturation (defaults): level=8, enable=0. acc goes 8, 16, 24, 31. `overflow` rises on the 4th RUN update; `ctrl` goes 1 two cycles after RUN entry and stays 1.
- Negative saturation: level=0, enable=1. acc goes −16, −32, −32. `overflow` sets on the 3rd update, not the 2nd. `ctrl` = 1, 0, 0… after the 2-cycle delay.
- Closed loop: enable tied to `ctrl`, level=8, run 100 cycles. d follows period 10 (five 1s, five 0s); acc stays within −24..16; `overflow` stays 0; `ctrl` density is 50%.
- Reset mid-RUN: after 20 RUN cycles of the saturation test, assert rst_n for 1 cycle. Next edge gives acc=0, `ctrl`=0, `ready`=0, `overflow`=0, and `ready` returns after 8 cycles.
- DELAY=1 / SETTLE=1 build: level=8, enable=0. `ready` goes high in cycle 2 after reset release; `ctrl`=1 one cycle after RUN entry.
